// File: rtl/cpu_edge_capture_pio_if.sv
// Avalon-MM slave bus for the edge-capture PIO: register select, write strobe and read data.
interface cpu_edge_capture_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/cpu_edge_capture_pio.sv
// Input PIO with synchroniser, sticky per-bit edge capture (W1C), IRQ mask and registered read path.
module cpu_edge_capture_pio #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 1,
  parameter int IRQ_TYPE    = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  cpu_edge_capture_pio_if.slave  bus,
  input  logic [WIDTH-1:0]       in_port,
  output logic                   irq
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] din, din_d_q, edge_det;
  logic [WIDTH-1:0] mask_q, mask_d, ec_q, ec_d, clr;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d, wr_en;
  logic             unused_wdata;

  assign unused_wdata = ^bus.writedata;

  // Stage 0 takes the raw pin; the last stage is the synchronised value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      din_d_q <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], in_port};
      din_d_q <= din;
    end
  end

  assign din = sync_q[SYNC_STAGES-1];

  always_comb begin
    edge_det = '0;
    case (EDGE_TYPE)
      1:       edge_det = din & ~din_d_q;
      2:       edge_det = ~din & din_d_q;
      3:       edge_det = din ^ din_d_q;
      default: edge_det = '0;
    endcase
  end

  assign wr_en  = bus.chipselect & ~bus.write_n;
  assign mask_d = (wr_en && bus.address == 2'd2) ? bus.writedata[WIDTH-1:0] : mask_q;
  assign clr    = (wr_en && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;
  // Set is OR'd in after the clear so a same-cycle edge survives the W1C.
  assign ec_d   = (ec_q & ~clr) | edge_det;

  always_comb begin
    readdata_d = '0;
    case (bus.address)
      2'd0:    readdata_d[WIDTH-1:0] = din;
      2'd2:    readdata_d[WIDTH-1:0] = mask_q;
      2'd3:    readdata_d[WIDTH-1:0] = ec_q;
      default: readdata_d = '0;
    endcase
  end

  always_comb begin
    irq_d = 1'b0;
    case (IRQ_TYPE)
      1:       irq_d = |(din & mask_q);
      2:       irq_d = |(ec_q & mask_q);
      default: irq_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q     <= '0;
      ec_q       <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      mask_q     <= mask_d;
      ec_q       <= ec_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign irq          = irq_q;

endmodule
